// File: rtl/encoder32_5_pending_if.sv
`default_nettype none
// ============================================================================
//  Module      : encoder32_5_pending_if
//  Description : Request/handshake bundle for the 32-to-5 pending encoder.
//                Signals:
//                  Req[31:0]     request pulses into the encoder
//                  Ack           consumer accepts the presented index
//                  Out[4:0]      presented binary index
//                  Valid         Out holds a live request
//                  Pending[31:0] pending-request vector
//                  Any           OR of Pending
//                Modports:
//                  master : the requester/consumer side (drives Req, Ack)
//                  slave  : the encoder side (drives Out, Valid, Pending, Any)
//  Revision    : 1.0  initial release
// ============================================================================
interface encoder32_5_pending_if;
   logic [31:0] Req;
   logic        Ack;
   logic [4:0]  Out;
   logic        Valid;
   logic [31:0] Pending;
   logic        Any;

   modport master (
      output Req,
      output Ack,
      input  Out,
      input  Valid,
      input  Pending,
      input  Any
   );

   modport slave (
      input  Req,
      input  Ack,
      output Out,
      output Valid,
      output Pending,
      output Any
   );
endinterface
`default_nettype wire

// File: rtl/encoder32_5_pending.sv
`default_nettype none
// ============================================================================
//  Module      : encoder32_5_pending
//  Description : Sequential 32-to-5 priority encoder with a pending-request
//                register. Request pulses are latched into Pending and issued
//                one at a time, lowest index first, under a Valid/Ack
//                handshake. A presented index is never pre-empted.
//                Ports:
//                  clk    : rising-edge clock
//                  reset  : synchronous active-high reset
//                  bus    : slave side of encoder32_5_pending_if
//                           (Req, Ack in; Out, Valid, Pending, Any out)
//  Revision    : 1.0  initial release
// ============================================================================
module encoder32_5_pending (
   input  wire                          clk,
   input  wire                          reset,
   encoder32_5_pending_if.slave         bus
);

   typedef enum logic [0:0] {
      S_IDLE    = 1'b0,
      S_PRESENT = 1'b1
   } state_t;

   state_t      state_q;
   logic [31:0] pending_q;
   logic [31:0] pending_d;
   logic [4:0]  out_q;
   logic        valid_q;

   logic [31:0] clr_w;
   logic [31:0] masked_w;
   logic [4:0]  sel_w;
   logic        have_w;

   // Selection works on the registered vector minus the bit being acked, so
   // the current cycle's Req never competes; it only lands in pending_d.
   always_comb begin
      clr_w = '0;
      if (valid_q && bus.Ack) begin
         clr_w = 32'd1 << out_q;
      end
      masked_w  = pending_q & ~clr_w;
      pending_d = masked_w | bus.Req;   // a re-request beats the clear
      have_w    = |masked_w;
      sel_w     = 5'd0;
      // Scan high to low so the lowest set index is the last one written.
      for (int i = 31; i >= 0; i--) begin
         if (masked_w[i]) begin
            sel_w = 5'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         pending_q <= '0;
         out_q     <= 5'd0;
         valid_q   <= 1'b0;
      end else begin
         pending_q <= pending_d;
         case (state_q)
            S_IDLE: begin
               if (have_w) begin
                  out_q   <= sel_w;
                  valid_q <= 1'b1;
                  state_q <= S_PRESENT;
               end
            end
            S_PRESENT: begin
               // Without Ack the presented index is held regardless of any
               // newly arriving lower-numbered request.
               if (bus.Ack) begin
                  if (have_w) begin
                     out_q   <= sel_w;
                  end else begin
                     valid_q <= 1'b0;
                     state_q <= S_IDLE;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.Out     = out_q;
   assign bus.Valid   = valid_q;
   assign bus.Pending = pending_q;
   assign bus.Any     = |pending_q;

endmodule
`default_nettype wire

// File: tb/tb_encoder32_5_pending.sv
`default_nettype none
// ============================================================================
//  Module      : tb_encoder32_5_pending
//  Description : Directed self-checking bench for encoder32_5_pending.
//                Expected indices are queued as requests are driven and
//                popped when a Valid/Ack handshake occurs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_encoder32_5_pending;

   logic clk;
   logic reset;
   int   nchk;
   int   nfail;
   int   exp_q[$];

   encoder32_5_pending_if bus ();

   encoder32_5_pending dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge; inputs change and outputs are sampled 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Performs one handshake with Ack already high: checks the presented index
   // against the scoreboard, then lets the edge happen.
   task automatic consume(input string tag);
      int e;
      chk({tag, "_valid"}, {31'd0, bus.Valid}, 32'd1);
      if (exp_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         chk(tag, {27'd0, bus.Out}, e);
      end
      step();
   endtask

   initial begin
      nchk  = 0;
      nfail = 0;
      reset    = 1'b1;
      bus.Req  = 32'hFFFF_FFFF;
      bus.Ack  = 1'b1;

      // ---- reset with hostile inputs
      step();
      chk("rst1_pending", bus.Pending, 32'd0);
      chk("rst1_valid",   {31'd0, bus.Valid}, 32'd0);
      step();
      chk("rst2_pending", bus.Pending, 32'd0);
      chk("rst2_out",     {27'd0, bus.Out}, 32'd0);
      chk("rst2_any",     {31'd0, bus.Any}, 32'd0);
      reset   = 1'b0;
      bus.Req = 32'd0;
      bus.Ack = 1'b0;
      step();
      chk("post_rst_pending", bus.Pending, 32'd0);
      chk("post_rst_valid",   {31'd0, bus.Valid}, 32'd0);
      chk("post_rst_any",     {31'd0, bus.Any}, 32'd0);

      // ---- single request, two-edge latency, hold without Ack
      bus.Req = 32'h0000_0400; exp_q.push_back(10);
      step();
      bus.Req = 32'd0;
      chk("single_any",     {31'd0, bus.Any}, 32'd1);
      chk("single_pend",    bus.Pending, 32'h0000_0400);
      chk("single_valid_e1", {31'd0, bus.Valid}, 32'd0);
      step();
      chk("single_valid", {31'd0, bus.Valid}, 32'd1);
      chk("single_out",   {27'd0, bus.Out}, 32'd10);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("single_hold", {27'd0, bus.Out}, 32'd10);
      end
      bus.Ack = 1'b1;
      consume("single_ack");
      bus.Ack = 1'b0;
      chk("single_clr_pend",  bus.Pending, 32'd0);
      chk("single_clr_valid", {31'd0, bus.Valid}, 32'd0);

      // ---- priority and back-to-back burst
      bus.Req = 32'h8000_0021;
      exp_q.push_back(0); exp_q.push_back(5); exp_q.push_back(31);
      step();
      bus.Req = 32'd0;
      step();
      bus.Ack = 1'b1;
      consume("burst0");
      consume("burst1");
      consume("burst2");
      bus.Ack = 1'b0;
      chk("burst_valid", {31'd0, bus.Valid}, 32'd0);
      chk("burst_any",   {31'd0, bus.Any}, 32'd0);

      // ---- no pre-emption by a lower index
      bus.Req = 32'h0010_0000; exp_q.push_back(20);
      step();
      bus.Req = 32'd0;
      step();
      chk("nopre_out", {27'd0, bus.Out}, 32'd20);
      bus.Req = 32'h0000_0008; exp_q.push_back(3);
      step();
      bus.Req = 32'd0;
      chk("nopre_hold", {27'd0, bus.Out}, 32'd20);
      chk("nopre_pend", bus.Pending, 32'h0010_0008);
      step();
      chk("nopre_hold2", {27'd0, bus.Out}, 32'd20);
      bus.Ack = 1'b1;
      consume("nopre_20");
      consume("nopre_3");
      bus.Ack = 1'b0;
      chk("nopre_done", {31'd0, bus.Valid}, 32'd0);

      // ---- re-request collides with the ack of the same line
      bus.Req = 32'h0000_0080; exp_q.push_back(7);
      step();
      bus.Req = 32'd0;
      step();
      bus.Ack = 1'b1;
      bus.Req = 32'h0000_0080; exp_q.push_back(7);
      consume("coll_first");
      bus.Ack = 1'b0;
      bus.Req = 32'd0;
      chk("coll_pend", bus.Pending, 32'h0000_0080);
      step();
      chk("coll_again_valid", {31'd0, bus.Valid}, 32'd1);
      bus.Ack = 1'b1;
      consume("coll_second");
      bus.Ack = 1'b0;
      chk("coll_clear", bus.Pending, 32'd0);
      chk("sb_drained", exp_q.size(), 32'd0);

      // ---- reset in the middle of a transfer
      bus.Req = 32'h0000_F000;
      step();
      bus.Req = 32'd0;
      step();
      chk("mid_out",  {27'd0, bus.Out}, 32'd12);
      chk("mid_pend", bus.Pending, 32'h0000_F000);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mid_rst_pend",  bus.Pending, 32'd0);
      chk("mid_rst_valid", {31'd0, bus.Valid}, 32'd0);
      bus.Ack = 1'b1;
      step();
      bus.Ack = 1'b0;
      chk("stray_pend",  bus.Pending, 32'd0);
      chk("stray_valid", {31'd0, bus.Valid}, 32'd0);
      chk("stray_out",   {27'd0, bus.Out}, 32'd0);
      step();
      chk("stray_any",   {31'd0, bus.Any}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/encoder32_5_pending.md
# encoder32_5_pending

Sequential 32-to-5 priority encoder with a pending-request register: the reverse of the 5-to-32 one-hot decoder. It collects single-cycle request pulses on 32 lines and issues them one at a time as a 5-bit binary index under a valid/ack handshake. The lowest-numbered pending line always goes first. It sits where decoded one-hot events (register-write strobes, interrupt lines, unit-done flags) must be funnelled back to an index consumed by the datapath or control unit.

## Interface
- Parameters: none; the widths are fixed at 32 request lines and a 5-bit index.
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- Req  in  32  request pulses; bit k high for one or more cycles sets pending bit k.
- Ack  in  1  consumer accepts the current Out; effective only while Valid=1.
- Out  out  5  registered binary index of the presented request.
- Valid  out  1  registered; Out holds a live request.
- Pending  out  32  registered pending vector, including the presented bit until it is acked.
- Any  out  1  registered; equals |Pending.

## Operation
- State machine has two states: IDLE and PRESENT.
- Registered state: Pending[31:0], Out[4:0], Valid, and state. Any is the OR-reduction of the registered Pending.
- Clear vector: Clr = onehot(Out) when (Valid & Ack), else 0.
- Pending update: Pending_next = (Pending & ~Clr) | Req.
  - Req wins over Clr on the same bit. If a line is re-requested in the cycle its index is acked, its pending bit stays set and the line is presented again later.
- Selection input: Sel = lowest set index of (Pending & ~Clr).
  - Sel is computed from the registered Pending, not the Pending_next value, so this cycle's Req never takes part in selection.
- Selection tie-break is fixed: the lowest index wins (index 0 has the highest priority).
- IDLE behaviour:
  - If (Pending & ~Clr) != 0: load Out <= Sel, Valid <= 1, go to PRESENT.
  - Otherwise: Valid stays 0 and Out holds its last value.
- PRESENT behaviour:
  - Ack=0: Out and Valid hold. A newly arriving lower index does not pre-empt the presented index; once presented, an index is stable until acked.
  - Ack=1 and (Pending & ~Clr) != 0: load Out <= Sel, Valid stays 1, stay in PRESENT. This gives back-to-back issue.
  - Ack=1 and (Pending & ~Clr) == 0: Valid <= 0, go to IDLE. Out holds its last value.
- Ack while Valid=0 is ignored and clears nothing.
- Only the bit named by Out is ever cleared; every other pending bit persists indefinitely.
- Reset overrides all other inputs, including in the middle of a transfer. Req and Ack in the reset cycle are discarded.

## Timing
- Reset values: Pending=0, Out=5'd0, Valid=0, Any=0, state=IDLE.
- Latency from request to presentation:
  - Req[k] sampled at edge t with the block idle and nothing pending.
  - Pending[k]=1 and Any=1 after edge t.
  - Valid=1 and Out=k after edge t+1 (two edges in total).
- Throughput: one index per cycle while Ack is held high and requests remain pending.
- The presented bit remains visible in Pending until the edge on which Ack is sampled.
- After the last ack, Valid falls on the same edge that clears the bit. The earliest subsequent presentation is one cycle later, because IDLE re-evaluates Pending.
- No combinational path exists from any input to any output; all outputs are registers or an OR of registers.

## Test plan
- Reset: drive Req=32'hFFFF_FFFF and Ack=1 with reset=1 for 2 cycles, then release with Req=0 -> Pending=0, Valid=0, Out=0 and Any=0 throughout, and still 0 one cycle after release.
- Single request: Req=32'h0000_0400 for one cycle -> Any=1 one edge later; Valid=1 and Out=10 two edges later. With Ack held 0 for 5 cycles, Out stays 10. One Ack cycle -> Pending=0 and Valid=0 on that edge.
- Priority and burst: Req=32'h8000_0021 for one cycle, then Ack held 1 -> Out presents 0, 5, 31 on consecutive cycles, then Valid=0 and Any=0.
- No pre-emption: with Out=20 presented and Ack=0, pulse Req[3] -> Out stays 20 and Pending=32'h0010_0008. Ack -> next Out=3.
- Re-request collision: with Out=7 presented, assert Ack=1 and Req[7]=1 in the same cycle -> Pending[7] stays 1, and Out=7 is presented again on the following cycle.
- Reset mid-operation: with Out=12 presented and Pending=32'h0000_F000, assert reset for one cycle -> Pending=0 and Valid=0 after that edge. A stray Ack afterwards has no effect.
